// File: rtl/sata_pkg.sv
// SATA scrambler LFSR constants and step/dword generator functions shared by
// the link-layer transmit path.
package sata_pkg;
    localparam int unsigned FILL_W  = 16;
    localparam int unsigned DWORD_W = 32;

    localparam logic [FILL_W-1:0] SATA_POLYNOMIAL = 16'ha011;
    localparam logic [FILL_W-1:0] SATA_INITIAL    = 16'hffff;

    typedef struct packed {
        logic [FILL_W-1:0] fill;
        logic              bit_out;
    } lfsr_step_t;

    typedef struct packed {
        logic [FILL_W-1:0]  fill;
        logic [DWORD_W-1:0] prn;
    } prn_dword_t;

    // One Galois step: emit the MSB, shift left, fold in the taps if MSB was set.
    function automatic lfsr_step_t lfsr_step(input logic [FILL_W-1:0] fill,
                                             input logic [FILL_W-1:0] poly);
        lfsr_step_t r;
        r.bit_out = fill[FILL_W-1];
        r.fill    = {fill[FILL_W-2:0], 1'b0} ^ (fill[FILL_W-1] ? poly : FILL_W'(0));
        return r;
    endfunction

    // 32 steps; bit k of the PRN dword is the k-th output bit.
    function automatic prn_dword_t lfsr_dword(input logic [FILL_W-1:0] fill,
                                              input logic [FILL_W-1:0] poly);
        prn_dword_t r;
        lfsr_step_t s;
        r.fill = fill;
        r.prn  = '0;
        for (int k = 0; k < DWORD_W; k++) begin
            s        = lfsr_step(r.fill, poly);
            r.prn[k] = s.bit_out;
            r.fill   = s.fill;
        end
        return r;
    endfunction
endpackage

// File: rtl/satatx_skidbuffer.sv
// One-entry input skid buffer; upstream ready is the registered "buffer empty" flag.
module satatx_skidbuffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid_c,
    input  logic         m_ready,
    output logic [W-1:0] m_data_c
);
    logic         r_valid;
    logic [W-1:0] r_data;

    // Park the incoming beat only when it arrives while downstream is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (s_valid && !r_valid && !m_ready)
                r_valid <= 1'b1;
            else if (m_ready)
                r_valid <= 1'b0;
            if (s_valid && !r_valid)
                r_data <= s_data;
        end
    end

    assign s_ready   = !r_valid;
    assign m_valid_c = s_valid || r_valid;
    assign m_data_c  = r_valid ? r_data : s_data;
endmodule

// File: rtl/satatx_scrambler_wide.sv
// NW-dword-per-beat SATA transmit scrambler with one output register stage.
// Define SATA_SCRAMBLER_SKID_EN to place a skid buffer on the input.
module satatx_scrambler_wide
    import sata_pkg::*;
#(
    parameter int unsigned       NW           = 1,
    parameter logic [FILL_W-1:0] POLYNOMIAL   = SATA_POLYNOMIAL,
    parameter logic [FILL_W-1:0] INITIAL      = SATA_INITIAL,
    parameter bit                OPT_LOWPOWER = 1'b1
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic [DWORD_W*NW-1:0] S_AXIS_TDATA,
    input  logic [NW-1:0]         S_AXIS_TKEEP,
    input  logic                  S_AXIS_TUSER,
    input  logic                  S_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic [DWORD_W*NW-1:0] M_AXIS_TDATA,
    output logic [NW-1:0]         M_AXIS_TKEEP,
    output logic                  M_AXIS_TUSER,
    output logic                  M_AXIS_TLAST
);
    localparam int unsigned DATA_W = DWORD_W * NW;
    localparam int unsigned BEAT_W = DATA_W + NW + 2;

    logic              core_valid, core_ready, accept;
    logic [DATA_W-1:0] core_data;
    logic [NW-1:0]     core_keep;
    logic              core_user, core_last;
    logic [FILL_W-1:0] fill, fill_next;
    logic [DATA_W-1:0] scr_data;

    assign core_ready = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign accept     = core_valid && core_ready;

`ifdef SATA_SCRAMBLER_SKID_EN
    logic [BEAT_W-1:0] skid_data;

    satatx_skidbuffer #(.W(BEAT_W)) u_skid (
        .clk       (S_AXI_ACLK),
        .reset     (S_AXI_ARESET),
        .s_valid   (S_AXIS_TVALID),
        .s_ready   (S_AXIS_TREADY),
        .s_data    ({S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TUSER, S_AXIS_TLAST}),
        .m_valid_c (core_valid),
        .m_ready   (core_ready),
        .m_data_c  (skid_data)
    );
    assign {core_data, core_keep, core_user, core_last} = skid_data;
`else
    assign core_valid    = S_AXIS_TVALID;
    assign core_data     = S_AXIS_TDATA;
    assign core_keep     = S_AXIS_TKEEP;
    assign core_user     = S_AXIS_TUSER;
    assign core_last     = S_AXIS_TLAST;
    assign S_AXIS_TREADY = core_ready;
`endif

    // Chain NW dword generators so dword j sees the fill after 32*j steps.
    always_comb begin : scramble
        prn_dword_t        d;
        logic [FILL_W-1:0] f;
        d        = '0;
        f        = fill;
        scr_data = '0;
        for (int j = 0; j < NW; j++) begin
            d = lfsr_dword(f, POLYNOMIAL);
            f = d.fill;
            if (core_keep[j])
                scr_data[DWORD_W*j +: DWORD_W] = core_data[DWORD_W*j +: DWORD_W]
                                               ^ (core_user ? DWORD_W'(0) : d.prn);
            else if (!OPT_LOWPOWER)
                scr_data[DWORD_W*j +: DWORD_W] = core_data[DWORD_W*j +: DWORD_W];
        end
        fill_next = f;
    end

    // Output register and LFSR state; TLAST re-seeds even on bypass beats.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            fill          <= INITIAL;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TKEEP  <= '0;
            M_AXIS_TUSER  <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (accept) begin
            if (core_last)
                fill <= INITIAL;
            else if (!core_user)
                fill <= fill_next;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= scr_data;
            M_AXIS_TKEEP  <= core_keep;
            M_AXIS_TUSER  <= core_user;
            M_AXIS_TLAST  <= core_last;
        end else if (core_ready) begin
            M_AXIS_TVALID <= 1'b0;
            if (OPT_LOWPOWER) begin
                M_AXIS_TDATA <= '0;
                M_AXIS_TKEEP <= '0;
                M_AXIS_TUSER <= 1'b0;
                M_AXIS_TLAST <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_satatx_scrambler_wide.sv
// Bench for satatx_scrambler_wide (NW=4): serial PRN-table reference model,
// scoreboard of expected beats, directed plus randomized frames.
module tb_satatx_scrambler_wide;
    localparam int unsigned NW    = 4;
    localparam int unsigned DW    = 32 * NW;
    localparam int unsigned BW    = DW + NW + 2;
    localparam int unsigned PRN_N = 256;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NW-1:0] keep;
        logic          user;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_user, s_last;
    logic [DW-1:0] s_data;
    logic [NW-1:0] s_keep;
    logic          m_valid, m_ready, m_user, m_last;
    logic [DW-1:0] m_data;
    logic [NW-1:0] m_keep;

    always #5 clk = ~clk;

    satatx_scrambler_wide #(
        .NW           (NW),
        .POLYNOMIAL   (16'ha011),
        .INITIAL      (16'hffff),
        .OPT_LOWPOWER (1'b1)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TREADY (s_ready),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TKEEP  (s_keep),
        .S_AXIS_TUSER  (s_user),
        .S_AXIS_TLAST  (s_last),
        .M_AXIS_TVALID (m_valid),
        .M_AXIS_TREADY (m_ready),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TKEEP  (m_keep),
        .M_AXIS_TUSER  (m_user),
        .M_AXIS_TLAST  (m_last)
    );

    logic [31:0] prn_tab [PRN_N];
    int unsigned pos;
    beat_t       exp_q[$];
    beat_t       held;
    logic        prev_stall;
    logic        acc;
    int          stall_cnt;
    logic        bp_rand;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Serial reference: the whole PRN stream from the seed, one dword per entry.
    task automatic build_prn();
        logic [15:0] f;
        logic [31:0] w;
        f = 16'hffff;
        for (int i = 0; i < PRN_N; i++) begin
            for (int k = 0; k < 32; k++) begin
                w[k] = f[15];
                f    = f[15] ? ((f << 1) ^ 16'ha011) : (f << 1);
            end
            prn_tab[i] = w;
        end
    endtask

    function automatic beat_t model(input beat_t b);
        beat_t e;
        e      = '0;
        e.keep = b.keep;
        e.user = b.user;
        e.last = b.last;
        for (int j = 0; j < NW; j++)
            if (b.keep[j])
                e.data[32*j +: 32] = b.data[32*j +: 32] ^ (b.user ? 32'h0 : prn_tab[(pos + j) % PRN_N]);
        return e;
    endfunction

    task automatic tick();
        beat_t ob, ib;
        logic  sr;
        @(negedge clk);
`ifdef SATA_SCRAMBLER_SKID_EN
        sr      = s_ready;
        m_ready = !m_ready;
        #1;
        chk("tready_registered", BW'(s_ready), BW'(sr));
        m_ready = !m_ready;
        #1;
`endif
        ob = {m_data, m_keep, m_user, m_last};
        if (prev_stall)
            chk("stall_hold", {m_valid, ob}, {1'b1, held});
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0)
                chk("extra_beat", BW'(m_valid), BW'(0));
            else
                chk("out_beat", ob, exp_q.pop_front());
        end
        acc = 1'b0;
        if (!rst && s_valid && s_ready) begin
            ib = {s_data, s_keep, s_user, s_last};
            exp_q.push_back(model(ib));
            if (s_last)      pos = 0;
            else if (!s_user) pos = pos + NW;
            acc = 1'b1;
        end
        prev_stall = !rst && m_valid && !m_ready;
        held       = ob;
        @(posedge clk);
        #1;
        if (stall_cnt > 0) begin
            m_ready = 1'b0;
            stall_cnt--;
        end else begin
            m_ready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [NW-1:0] k, input logic u, input logic l);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_user  = u;
        s_last  = l;
        acc     = 1'b0;
        while (!acc && n < 100) begin
            tick();
            n++;
        end
        if (!acc) chk("accept_timeout", BW'(acc), BW'(1));
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n       = 0;
        bp_rand = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty", BW'(exp_q.size()), BW'(0));
        tick();
        tick();
        chk("idle_valid", BW'(m_valid), BW'(0));
        chk("idle_fields_zero", {m_data, m_keep, m_user, m_last}, BW'(0));
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < NW; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [DW-1:0] bypass_word;
        int            len, kn;
        build_prn();
        pos = 0; prev_stall = 1'b0; acc = 1'b0; stall_cnt = 0; bp_rand = 1'b0;
        rst = 1'b1; m_ready = 1'b1;
        s_valid = 1'b0; s_data = '0; s_keep = '0; s_user = 1'b0; s_last = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_valid", BW'(m_valid), BW'(0));
        chk("reset_fields", {m_data, m_keep, m_user, m_last}, BW'(0));

        // Zero data: output is the raw PRN stream, restarting after TLAST.
        for (int b = 0; b < 8; b++) send('0, 4'hf, 1'b0, 1'b0);
        send('0, 4'hf, 1'b0, 1'b1);
        send('0, 4'hf, 1'b0, 1'b0);
        send('0, 4'hf, 1'b0, 1'b1);
        drain();

        // Three-beat random frame (twelve dwords), back to back.
        send(rand_data(), 4'hf, 1'b0, 1'b0);
        send(rand_data(), 4'hf, 1'b0, 1'b0);
        send(rand_data(), 4'hf, 1'b0, 1'b1);
        drain();

        // Mid-frame primitive leaves the LFSR untouched.
        for (int i = 0; i < NW; i++) bypass_word[32*i +: 32] = 32'h7C95B5B5;
        send(rand_data(), 4'hf, 1'b0, 1'b0);
        send(bypass_word, 4'hf, 1'b1, 1'b0);
        send(rand_data(), 4'hf, 1'b0, 1'b1);
        drain();

        // Partial last beat, then a new frame from the seed.
        send(rand_data(), 4'hf, 1'b0, 1'b0);
        send(rand_data(), 4'b0011, 1'b0, 1'b1);
        send(rand_data(), 4'hf, 1'b0, 1'b1);
        drain();

        // Five-cycle output stall in the middle of a frame.
        send(rand_data(), 4'hf, 1'b0, 1'b0);
        stall_cnt = 5;
        send(rand_data(), 4'hf, 1'b0, 1'b0);
        send(rand_data(), 4'hf, 1'b0, 1'b0);
        send(rand_data(), 4'hf, 1'b0, 1'b1);
        drain();

        // Random frames with random backpressure, primitives and partial ends.
        for (int fr = 0; fr < 12; fr++) begin
            bp_rand = 1'b1;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len - 1; b++)
                send(rand_data(), 4'hf, ($urandom_range(0, 3) == 0), 1'b0);
            kn = $urandom_range(1, 4);
            send(rand_data(), NW'((1 << kn) - 1), ($urandom_range(0, 5) == 0), 1'b1);
        end
        drain();

        // Reset after the second beat of a frame abandons it.
        send(rand_data(), 4'hf, 1'b0, 1'b0);
        send(rand_data(), 4'hf, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        pos = 0;
        prev_stall = 1'b0;
        chk("midreset_valid", BW'(m_valid), BW'(0));
        send(rand_data(), 4'hf, 1'b0, 1'b0);
        send(rand_data(), 4'b0111, 1'b0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
